// File: rtl/ioctl_rom_pkg.sv
// Shared constants and types for the ioctl ROM download router.
package ioctl_rom_pkg;

    localparam int unsigned IOCTL_ADDR_W = 25;

    localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
    localparam logic [7:0] CFG_INDEX_DEF = 8'd1;
    localparam logic [7:0] DIP_INDEX_DEF = 8'd254;

    typedef logic [IOCTL_ADDR_W-1:0] ioctl_addr_t;

endpackage

// File: rtl/rom_reset_gen.sv
// Tracks the first completed ROM download and stretches the game-core reset.
module rom_reset_gen #(
    parameter logic [15:0] RST_HOLD = 16'hFFFF
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic rom_dl,
    input  logic status_reset,
    input  logic button_reset,
    output logic rom_loaded,
    output logic core_reset
);

    localparam int unsigned CNT_W = 16;

    logic             dl_last_q;
    logic             loaded_q, loaded_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_q, rst_d;

    // Next state: sticky loaded flag, reloading/saturating counter, reset from counter
    always_comb begin
        loaded_d = loaded_q | (dl_last_q & ~rom_dl);
        cnt_d    = cnt_q;
        rst_d    = (cnt_q != '0);
        if (status_reset || button_reset || !loaded_q || rom_dl) begin
            cnt_d = RST_HOLD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State registers with synchronous reset holding the core in reset
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dl_last_q <= 1'b0;
            loaded_q  <= 1'b0;
            cnt_q     <= RST_HOLD;
            rst_q     <= 1'b1;
        end else begin
            dl_last_q <= rom_dl;
            loaded_q  <= loaded_d;
            cnt_q     <= cnt_d;
            rst_q     <= rst_d;
        end
    end

    assign rom_loaded = loaded_q;
    assign core_reset = rst_q;

endmodule

// File: rtl/ioctl_rom_router.sv
// Routes HPS ioctl ROM bytes to NUM_PORTS SDRAM write ports by address window,
// captures core_mod / DIP bytes and drives the stretched core reset.
// Build option ROM_CHECKSUM_EN adds rom_sum, a 16-bit sum of accepted ROM bytes.
module ioctl_rom_router
    import ioctl_rom_pkg::*;
#(
    parameter int unsigned                 NUM_PORTS  = 2,
    parameter int unsigned                 ADDR_W     = IOCTL_ADDR_W,
    parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_BASE  = {ioctl_addr_t'(25'h30000), ioctl_addr_t'(25'h0)},
    parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_LIMIT = {ioctl_addr_t'(25'hA0000), ioctl_addr_t'(25'hA0000)},
    parameter logic [7:0]                  ROM_INDEX  = ROM_INDEX_DEF,
    parameter logic [7:0]                  CFG_INDEX  = CFG_INDEX_DEF,
    parameter logic [7:0]                  DIP_INDEX  = DIP_INDEX_DEF,
    parameter int unsigned                 DIP_BYTES  = 8,
    parameter logic [15:0]                 RST_HOLD   = 16'hFFFF
) (
    input  logic                            clk_sys,
    input  logic                            reset_n,
    input  logic                            ioctl_download,
    input  logic [7:0]                      ioctl_index,
    input  logic                            ioctl_wr,
    input  logic [ADDR_W-1:0]               ioctl_addr,
    input  logic [7:0]                      ioctl_dout,
    output logic                            ioctl_wait,
    input  logic                            status_reset,
    input  logic                            button_reset,
    output logic [NUM_PORTS-1:0]            port_req,
    input  logic [NUM_PORTS-1:0]            port_ack,
    output logic [NUM_PORTS*(ADDR_W-2)-1:0] port_a,
    output logic [NUM_PORTS*2-1:0]          port_ds,
    output logic [15:0]                     port_d,
    output logic                            port_we,
    output logic                            rom_dl,
    output logic [7:0]                      core_mod,
    output logic [DIP_BYTES*8-1:0]          dip_sw,
    output logic                            rom_loaded,
    output logic                            core_reset,
    output logic                            overrun
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0]                     rom_sum
`endif
);

    localparam int unsigned PA_W  = ADDR_W - 2;
    localparam int unsigned DIP_W = DIP_BYTES * 8;

    logic                 wr_last_q;
    logic                 wr_rise_c, rom_wr_c, drop_c;
    logic [NUM_PORTS-1:0] hit_c, busy_c;
    logic [ADDR_W-1:0]    offs_c [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_q, req_d;
    logic [PA_W-1:0]      pa_q [NUM_PORTS];
    logic [PA_W-1:0]      pa_d [NUM_PORTS];
    logic [1:0]           ds_q [NUM_PORTS];
    logic [1:0]           ds_d [NUM_PORTS];
    logic [15:0]          pd_q, pd_d;
    logic [7:0]           core_mod_q, core_mod_d;
    logic [DIP_W-1:0]     dip_q, dip_d;
    logic                 ovr_q, ovr_d;

    assign rom_dl     = ioctl_download && (ioctl_index == ROM_INDEX);
    assign port_we    = rom_dl;
    assign wr_rise_c  = ioctl_wr && !wr_last_q;
    assign rom_wr_c   = rom_dl && wr_rise_c;
    assign busy_c     = req_q ^ port_ack;
    assign drop_c     = |(hit_c & busy_c);
    assign ioctl_wait = |busy_c;

    // Per-port window decode; a single unsigned compare on the wrapped offset covers both bounds
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic [ADDR_W-1:0] BASE  = PORT_BASE[p*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] LIMIT = PORT_LIMIT[p*ADDR_W +: ADDR_W];
        assign offs_c[p]                = ioctl_addr - BASE;
        assign hit_c[p]                 = (offs_c[p] < (LIMIT - BASE));
        assign port_a[p*PA_W +: PA_W]   = pa_q[p];
        assign port_ds[2*p +: 2]        = ds_q[p];
    end

    // Next state: ROM routing with all-or-nothing drop, config and DIP capture
    always_comb begin
        req_d      = req_q;
        pa_d       = pa_q;
        ds_d       = ds_q;
        pd_d       = pd_q;
        core_mod_d = core_mod_q;
        dip_d      = dip_q;
        ovr_d      = ovr_q;
        if (rom_wr_c) begin
            if (drop_c) begin
                ovr_d = 1'b1;
            end else begin
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    if (hit_c[p]) begin
                        req_d[p] = ~req_q[p];
                        pa_d[p]  = PA_W'(offs_c[p] >> 1);
                        ds_d[p]  = {ioctl_addr[0], ~ioctl_addr[0]};
                        pd_d     = {ioctl_dout, ioctl_dout};
                    end
                end
            end
        end
        if (wr_rise_c && (ioctl_index == CFG_INDEX) && (ioctl_addr == '0)) begin
            core_mod_d = ioctl_dout;
        end
        if (wr_rise_c && (ioctl_index == DIP_INDEX)) begin
            for (int unsigned k = 0; k < DIP_BYTES; k++) begin
                if (ioctl_addr == ADDR_W'(k)) begin
                    dip_d[8*k +: 8] = ioctl_dout;
                end
            end
        end
    end

    // Router registers
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_last_q  <= 1'b0;
            req_q      <= '0;
            pa_q       <= '{default: '0};
            ds_q       <= '{default: '0};
            pd_q       <= '0;
            core_mod_q <= '0;
            dip_q      <= '0;
            ovr_q      <= 1'b0;
        end else begin
            wr_last_q  <= ioctl_wr;
            req_q      <= req_d;
            pa_q       <= pa_d;
            ds_q       <= ds_d;
            pd_q       <= pd_d;
            core_mod_q <= core_mod_d;
            dip_q      <= dip_d;
            ovr_q      <= ovr_d;
        end
    end

    assign port_req = req_q;
    assign port_d   = pd_q;
    assign core_mod = core_mod_q;
    assign dip_sw   = dip_q;
    assign overrun  = ovr_q;

`ifdef ROM_CHECKSUM_EN
    logic        dl_q;
    logic        accept_c;
    logic [15:0] sum_q, sum_d;

    assign accept_c = rom_wr_c && (|hit_c) && !drop_c;

    // Running byte sum, restarted when a new ROM download begins
    always_comb begin
        sum_d = (rom_dl && !dl_q) ? '0 : sum_q;
        if (accept_c) begin
            sum_d = sum_d + 16'(ioctl_dout);
        end
    end

    // Checksum registers
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dl_q  <= 1'b0;
            sum_q <= '0;
        end else begin
            dl_q  <= rom_dl;
            sum_q <= sum_d;
        end
    end

    assign rom_sum = sum_q;
`endif

    rom_reset_gen #(
        .RST_HOLD (RST_HOLD)
    ) u_reset_gen (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .rom_dl       (rom_dl),
        .status_reset (status_reset),
        .button_reset (button_reset),
        .rom_loaded   (rom_loaded),
        .core_reset   (core_reset)
    );

endmodule
